// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
// Optional parity frame bit is enabled by defining SEQ_GEN_PARITY_EN.
package seq_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    GAP,
    DONE
  } state_e;

  localparam logic [3:0] PAT_1010       = 4'b1010;
  localparam int         GAP_CYCLES_DEF = 1;

endpackage

// File: rtl/seq_gen_piso.sv
// Parallel-in / serial-out shift register, MSB first; load takes priority over shift.
module seq_piso #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] par_i,
  output logic         ser_o
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = par_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Sends a captured pattern MSB-first repeat_cnt times with idle gaps, then pulses done.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PATTERN_W  = 4,
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_cnt,
  output logic                 busy,
  output logic                 out,
  output logic                 out_valid,
  output logic                 done
);

  localparam int IDX_W = $clog2(PATTERN_W);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(PATTERN_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]     rep_q, rep_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [GAP_W-1:0]     gap_q, gap_d;

  logic                 load_en;
  logic                 shift_en;
  logic [PATTERN_W-1:0] load_dat;
  logic                 frame_end;
  logic                 ser_bit;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    load_dat  = pat_q;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (repeat_cnt != '0) begin
            pat_d    = pattern;
            rep_d    = repeat_cnt;
            idx_d    = BIT_LAST;
            load_en  = 1'b1;
            load_dat = pattern;
            state_d  = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        idx_d    = idx_q - 1'b1;
        if (idx_q == '0) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = PARITY;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: begin
        frame_end = 1'b1;
      end
`endif
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          load_en = 1'b1;
          idx_d   = BIT_LAST;
          state_d = SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // rep_q is compared before decrementing, so a full-scale count never wraps
    if (frame_end) begin
      rep_d = rep_q - 1'b1;
      if (rep_q == CNT_W'(1)) begin
        state_d = DONE;
      end else if (GAP_CYCLES > 0) begin
        gap_d   = '0;
        state_d = GAP;
      end else begin
        load_en = 1'b1;
        idx_d   = BIT_LAST;
        state_d = SHIFT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  seq_piso #(
    .W (PATTERN_W)
  ) u_piso (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load_en),
    .shift_i (shift_en),
    .par_i   (load_dat),
    .ser_o   (ser_bit)
  );

  // Outputs decode straight from registered state and shift data
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    out_valid = 1'b0;
    out       = 1'b0;
    if (state_q == SHIFT) begin
      out_valid = 1'b1;
      out       = ser_bit;
    end
`ifdef SEQ_GEN_PARITY_EN
    if (state_q == PARITY) begin
      out_valid = 1'b1;
      out       = ^pat_q;
    end
`endif
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: inputs driven and outputs sampled on the falling edge.
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_cnt;
  logic       busy;
  logic       out;
  logic       out_valid;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_GEN_PARITY_EN
  seq_pattern_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_CYCLES(0)) u_dut (
`else
  seq_pattern_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_CYCLES(1)) u_dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .busy       (busy),
    .out        (out),
    .out_valid  (out_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pattern = 4'b1010; repeat_cnt = 4'd2;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 2) begin rst = 1'b0; start = 1'b0; end
      checks++;
      if ({busy, out, out_valid, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: busy/out/valid/done=%b expected 0000", c, {busy, out, out_valid, done});
      end
    end
  endtask

  task automatic test_basic();
    logic [1:11] e_out, e_vld, e_done, e_busy;
    e_out  = 11'b10100101000;
    e_vld  = 11'b11110111100;
    e_done = 11'b00000000010;
    e_busy = 11'b11111111110;
    @(negedge clk); start = 1'b1; pattern = 4'b1010; repeat_cnt = 4'd2;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if ({out, out_valid, done, busy} !== {e_out[c], e_vld[c], e_done[c], e_busy[c]}) begin
        errors++;
        $display("FAIL basic cycle %0d: out/vld/done/busy=%b expected %b", c,
                 {out, out_valid, done, busy}, {e_out[c], e_vld[c], e_done[c], e_busy[c]});
      end
    end
  endtask

  task automatic test_busy_protect();
    logic [1:13] e_out, e_vld, e_done;
    e_out  = 13'b1010010100000;
    e_vld  = 13'b1111011110000;
    e_done = 13'b0000000001000;
    @(negedge clk); start = 1'b1; pattern = 4'b1010; repeat_cnt = 4'd2;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 3) begin start = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd5; end
      if (c == 4) start = 1'b0;
      checks++;
      if ({out, out_valid, done} !== {e_out[c], e_vld[c], e_done[c]}) begin
        errors++;
        $display("FAIL busy_protect cycle %0d: out/vld/done=%b expected %b", c,
                 {out, out_valid, done}, {e_out[c], e_vld[c], e_done[c]});
      end
    end
  endtask

  task automatic test_zero_repeat();
    logic [1:4] e_done, e_busy;
    e_done = 4'b1000;
    e_busy = 4'b1000;
    // start held through the DONE cycle must not relaunch
    @(negedge clk); start = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) repeat_cnt = 4'd3;
      if (c == 2) start = 1'b0;
      checks++;
      if ({out_valid, out, done, busy} !== {2'b00, e_done[c], e_busy[c]}) begin
        errors++;
        $display("FAIL zero_repeat cycle %0d: vld/out/done/busy=%b expected %b", c,
                 {out_valid, out, done, busy}, {2'b00, e_done[c], e_busy[c]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:3] e_out;
    logic [1:6] f_out, f_vld, f_done, f_busy;
    e_out  = 3'b101;
    f_out  = 6'b110000;
    f_vld  = 6'b111100;
    f_done = 6'b000010;
    f_busy = 6'b111110;
    @(negedge clk); start = 1'b1; pattern = 4'b1010; repeat_cnt = 4'd2;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if (c <= 3) begin
        if ({out, out_valid} !== {e_out[c], 1'b1}) begin
          errors++;
          $display("FAIL reset_mid run cycle %0d: out/vld=%b expected %b", c, {out, out_valid}, {e_out[c], 1'b1});
        end
      end else if ({busy, out_valid, out, done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid idle cycle %0d: busy/vld/out/done=%b expected 0000", c, {busy, out_valid, out, done});
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
    end
    @(negedge clk); start = 1'b1; pattern = 4'b1100; repeat_cnt = 4'd1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if ({out, out_valid, done, busy} !== {f_out[c], f_vld[c], f_done[c], f_busy[c]}) begin
        errors++;
        $display("FAIL reset_mid restart cycle %0d: out/vld/done/busy=%b expected %b", c,
                 {out, out_valid, done, busy}, {f_out[c], f_vld[c], f_done[c], f_busy[c]});
      end
    end
  endtask

  task automatic test_max_count();
    int n_vld = 0;
    int n_ones = 0;
    int n_done = 0;
    int done_at = 0;
    @(negedge clk); start = 1'b1; pattern = 4'b1001; repeat_cnt = 4'd15;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (out_valid) n_vld++;
      if (out) n_ones++;
      if (done) begin n_done++; done_at = c; end
    end
    checks++;
    if (n_vld !== 60) begin
      errors++;
      $display("FAIL max_count valid bits: got %0d expected 60", n_vld);
    end
    checks++;
    if (n_ones !== 30) begin
      errors++;
      $display("FAIL max_count one bits: got %0d expected 30", n_ones);
    end
    checks++;
    if (n_done !== 1 || done_at !== 75) begin
      errors++;
      $display("FAIL max_count done: %0d pulses at cycle %0d expected 1 at 75", n_done, done_at);
    end
  endtask

  task automatic test_parity();
    logic [1:7] e_out, e_vld, e_done;
    e_out  = 7'b1011100;
    e_vld  = 7'b1111100;
    e_done = 7'b0000010;
    @(negedge clk); start = 1'b1; pattern = 4'b1011; repeat_cnt = 4'd1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      checks++;
      if ({out, out_valid, done} !== {e_out[c], e_vld[c], e_done[c]}) begin
        errors++;
        $display("FAIL parity cycle %0d: out/vld/done=%b expected %b", c,
                 {out, out_valid, done}, {e_out[c], e_vld[c], e_done[c]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = 4'b0000; repeat_cnt = 4'd0;
    test_reset();
`ifdef SEQ_GEN_PARITY_EN
    test_parity();
`else
    test_basic();
    test_busy_protect();
    test_zero_repeat();
    test_reset_mid();
    test_max_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
